// File: rtl/clock_reset_sequencer.sv
// Holds the subsystem in reset until MMCM lock has been stable long enough,
// re-asserts reset on lock loss, and pulses an MMCM reset if lock never arrives.
module clock_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int STABLE_CYCLES       = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MMCM_RST_CYCLES     = 16,
    parameter int COUNT_WIDTH         = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mmcm_locked,
    output logic                   o_rst_n,
    output logic                   o_ready,
    output logic                   o_mmcm_rst,
    output logic [1:0]             o_state,
    output logic [COUNT_WIDTH-1:0] o_lock_loss_count
);

    localparam int MAX_AB = (STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > MMCM_RST_CYCLES) ? MAX_AB : MMCM_RST_CYCLES;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MRST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] LOSS_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABILIZE  = 2'd1,
        RUN        = 2'd2,
        MMCM_RESET = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   rst_n_reg;
    logic                   ready_reg;
    logic                   mmcm_rst_reg;
    logic [COUNT_WIDTH-1:0] loss_cnt_reg;

    // LOCKED is asynchronous to i_clk; only the last stage is trusted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_mmcm_locked};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    // Outputs are decoded from the state being entered so they switch on the
    // same edge as the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= WAIT_LOCK;
            cnt_reg      <= '0;
            rst_n_reg    <= 1'b0;
            ready_reg    <= 1'b0;
            mmcm_rst_reg <= 1'b0;
            loss_cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            case (state_reg)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_reg <= STABILIZE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg    <= MMCM_RESET;
                        cnt_reg      <= '0;
                        mmcm_rst_reg <= 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        rst_n_reg <= 1'b1;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_reg <= '0;
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        rst_n_reg <= 1'b0;
                        ready_reg <= 1'b0;
                        if (loss_cnt_reg != LOSS_MAX) begin
                            loss_cnt_reg <= loss_cnt_reg + COUNT_WIDTH'(1);
                        end
                    end
                end
                MMCM_RESET: begin
                    // Lock is ignored here so the pulse always has full width.
                    if (cnt_reg == MRST_LAST) begin
                        state_reg    <= WAIT_LOCK;
                        cnt_reg      <= '0;
                        mmcm_rst_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= WAIT_LOCK;
                    cnt_reg      <= '0;
                    rst_n_reg    <= 1'b0;
                    ready_reg    <= 1'b0;
                    mmcm_rst_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst_n           = rst_n_reg;
    assign o_ready           = ready_reg;
    assign o_mmcm_rst        = mmcm_rst_reg;
    assign o_state           = state_reg;
    assign o_lock_loss_count = loss_cnt_reg;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer with small timing parameters;
// expected outputs are queued per step and compared a fixed number of edges later.
module tb_clock_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       rst_n;
    logic       ready;
    logic       mmcm_rst;
    logic [1:0] state;
    logic [1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] state;
        logic       rst_n;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    clock_reset_sequencer #(
        .SYNC_STAGES        (2),
        .STABLE_CYCLES      (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MMCM_RST_CYCLES    (4),
        .COUNT_WIDTH        (2)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_mmcm_locked    (locked),
        .o_rst_n          (rst_n),
        .o_ready          (ready),
        .o_mmcm_rst       (mmcm_rst),
        .o_state          (state),
        .o_lock_loss_count(loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Push the expected outputs, run n edges, then pop and compare.
    task automatic step(input int n, input string tag, input logic [1:0] exp_state,
                        input logic exp_rst_n, input logic [1:0] exp_cnt);
        exp_t e;
        exp_t got;
        e.tag   = tag;
        e.state = exp_state;
        e.rst_n = exp_rst_n;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        cyc(n);
        got = sb_q.pop_front();
        checks++;
        assert (state === got.state) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", got.tag, state, got.state);
        end
        checks++;
        assert (rst_n === got.rst_n) else begin
            errors++;
            $error("FAIL %s rst_n: got %b expected %b", got.tag, rst_n, got.rst_n);
        end
        checks++;
        assert (ready === got.rst_n) else begin
            errors++;
            $error("FAIL %s ready: got %b expected %b", got.tag, ready, got.rst_n);
        end
        checks++;
        assert (mmcm_rst === (got.state == 2'd3)) else begin
            errors++;
            $error("FAIL %s mmcm_rst: got %b expected %b", got.tag, mmcm_rst, (got.state == 2'd3));
        end
        checks++;
        assert (loss_cnt === got.cnt) else begin
            errors++;
            $error("FAIL %s count: got %0d expected %0d", got.tag, loss_cnt, got.cnt);
        end
        $display("step %-14s state=%0d rst_n=%b ready=%b mmcm_rst=%b count=%0d",
                 tag, state, rst_n, ready, mmcm_rst, loss_cnt);
    endtask

    // From RUN: drop lock for the sampled edge j, expect reset at j+2, re-release 10 edges after re-lock.
    task automatic lose_and_regain(input logic [1:0] exp_cnt_before, input logic [1:0] exp_cnt_after);
        locked = 1'b0;
        step(1, "drop_j", 2'd2, 1'b1, exp_cnt_before);
        step(1, "drop_j1", 2'd2, 1'b1, exp_cnt_before);
        step(1, "drop_j2", 2'd0, 1'b0, exp_cnt_after);
        locked = 1'b1;
        step(10, "relock_k9", 2'd1, 1'b0, exp_cnt_after);
        step(1, "relock_k10", 2'd2, 1'b1, exp_cnt_after);
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        step(3, "reset", 2'd0, 1'b0, 2'd0);

        // 1: basic release, 10 edges after lock is first sampled
        rst    = 1'b0;
        locked = 1'b1;
        step(2, "t1_k1", 2'd0, 1'b0, 2'd0);
        step(1, "t1_k2", 2'd1, 1'b0, 2'd0);
        step(7, "t1_k9", 2'd1, 1'b0, 2'd0);
        step(1, "t1_k10", 2'd2, 1'b1, 2'd0);
        step(5, "t1_hold", 2'd2, 1'b1, 2'd0);

        // 2: one-cycle glitch during STABILIZE restarts it
        rst = 1'b1;
        step(1, "t2_reset", 2'd0, 1'b0, 2'd0);
        rst    = 1'b0;
        locked = 1'b1;
        step(7, "t2_stab", 2'd1, 1'b0, 2'd0);
        locked = 1'b0;
        step(1, "t2_glitch", 2'd1, 1'b0, 2'd0);
        locked = 1'b1;
        step(2, "t2_back_wait", 2'd0, 1'b0, 2'd0);
        step(1, "t2_restab", 2'd1, 1'b0, 2'd0);
        step(7, "t2_k9", 2'd1, 1'b0, 2'd0);
        step(1, "t2_k10", 2'd2, 1'b1, 2'd0);

        // 4: repeated lock loss, saturating count
        lose_and_regain(2'd0, 2'd1);
        lose_and_regain(2'd1, 2'd2);
        lose_and_regain(2'd2, 2'd3);
        lose_and_regain(2'd3, 2'd3);

        // 5: synchronous reset mid-RUN with count=2
        rst = 1'b1;
        step(1, "t5_pre_reset", 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        step(11, "t5_run", 2'd2, 1'b1, 2'd0);
        lose_and_regain(2'd0, 2'd1);
        lose_and_regain(2'd1, 2'd2);
        rst = 1'b1;
        step(1, "t5_reset_run", 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        step(9, "t5_k8", 2'd1, 1'b0, 2'd0);
        step(1, "t5_k9", 2'd1, 1'b0, 2'd0);
        step(1, "t5_k10", 2'd2, 1'b1, 2'd0);

        // 3: no lock -> periodic MMCM reset, lock during the pulse does not shorten it
        rst    = 1'b1;
        locked = 1'b0;
        step(1, "t3_reset", 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        step(31, "t3_r31", 2'd0, 1'b0, 2'd0);
        step(1, "t3_r32", 2'd3, 1'b0, 2'd0);
        step(3, "t3_r35", 2'd3, 1'b0, 2'd0);
        step(1, "t3_r36", 2'd0, 1'b0, 2'd0);
        step(31, "t3_r67", 2'd0, 1'b0, 2'd0);
        step(1, "t3_r68", 2'd3, 1'b0, 2'd0);
        locked = 1'b1;
        step(3, "t3_r71", 2'd3, 1'b0, 2'd0);
        step(1, "t3_r72", 2'd0, 1'b0, 2'd0);
        step(1, "t3_r73", 2'd1, 1'b0, 2'd0);

        // 6: lock coincides with the WAIT_LOCK timeout
        rst    = 1'b1;
        locked = 1'b0;
        step(1, "t6_reset", 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        step(29, "t6_r29", 2'd0, 1'b0, 2'd0);
        locked = 1'b1;
        step(2, "t6_r31", 2'd0, 1'b0, 2'd0);
        step(1, "t6_r32", 2'd1, 1'b0, 2'd0);
        step(7, "t6_r39", 2'd1, 1'b0, 2'd0);
        step(1, "t6_r40", 2'd2, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
